// File: rtl/lsu_ctrl.sv
// lsu_ctrl: sequences one CPU load/store at a time through the memunit handshake,
// moving data between the register file and memory with a per-phase timeout.
module lsu_ctrl #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        req_valid,
    input  logic        req_load,
    input  logic [15:0] req_addr,
    input  logic [3:0]  req_reg,
    output logic        req_ready,
    output logic        done,
    output logic        err,
    output logic [15:0] m_addr,
    output logic        m_enable,
    output logic        m_rwn,
    output logic [15:0] m_idata,
    input  logic        m_ready,
    input  logic [15:0] m_odata,
    input  logic        m_data_valid,
    output logic [3:0]  rf_wsel,
    output logic [15:0] rf_wdata,
    output logic        rf_we,
    output logic [3:0]  rf_rsel,
    input  logic [15:0] rf_rdata
);
    typedef enum logic [2:0] {IDLE, ARM, ISSUE, WAIT, DONE} state_t;

    state_t      state;
    logic [15:0] cnt;
    logic        got_data;
    logic        expired;
    logic        take_data;

    // the cycle being decided is the TIMEOUT_CYCLES-th one spent in the phase
    assign expired   = cnt == TIMEOUT_CYCLES - 16'd1;
    assign take_data = m_rwn && m_data_valid && !got_data;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            cnt       <= 16'd0;
            got_data  <= 1'b0;
            req_ready <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            m_addr    <= 16'd0;
            m_enable  <= 1'b0;
            m_rwn     <= 1'b0;
            m_idata   <= 16'd0;
            rf_wsel   <= 4'd0;
            rf_wdata  <= 16'd0;
            rf_we     <= 1'b0;
            rf_rsel   <= 4'd0;
        end else begin
            rf_we <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            cnt   <= cnt + 16'd1;
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_ready && req_valid) begin
                        req_ready <= 1'b0;
                        m_addr    <= req_addr;
                        m_rwn     <= req_load;
                        rf_rsel   <= req_reg;
                        got_data  <= 1'b0;
                        cnt       <= 16'd0;
                        state     <= ARM;
                    end
                end
                ARM: begin
                    if (m_ready) begin
                        if (!m_rwn) m_idata <= rf_rdata;
                        m_enable <= 1'b1;
                        cnt      <= 16'd0;
                        state    <= ISSUE;
                    end else if (expired) begin
                        done  <= 1'b1;
                        err   <= 1'b1;
                        state <= DONE;
                    end
                end
                ISSUE: begin
                    if (!m_ready) begin
                        m_enable <= 1'b0;
                        cnt      <= 16'd0;
                        state    <= WAIT;
                    end else if (expired) begin
                        m_enable <= 1'b0;
                        done     <= 1'b1;
                        err      <= 1'b1;
                        state    <= DONE;
                    end
                end
                WAIT: begin
                    if (!m_ready && expired) begin
                        done  <= 1'b1;
                        err   <= 1'b1;
                        state <= DONE;
                    end else begin
                        if (take_data) begin
                            rf_we    <= 1'b1;
                            rf_wsel  <= rf_rsel;
                            rf_wdata <= m_odata;
                            got_data <= 1'b1;
                        end
                        // read data arriving with the ready rise still counts as delivered
                        if (m_ready) begin
                            done  <= 1'b1;
                            err   <= m_rwn && !(got_data || take_data);
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed load/store scenarios against a memunit responder and a transaction-level model.
module tb_lsu_ctrl;
    localparam logic [15:0] TMO = 16'd16;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_load = 1'b0;
    logic [15:0] req_addr = 16'd0;
    logic [3:0]  req_reg = 4'd0;
    logic        req_ready, done, err, m_enable, m_rwn, rf_we;
    logic [15:0] m_addr, m_idata, rf_wdata, rf_rdata;
    logic [3:0]  rf_wsel, rf_rsel;
    logic        m_ready = 1'b0;
    logic        m_data_valid = 1'b0;
    logic [15:0] m_odata = 16'd0;

    int checks = 0;
    int errors = 0;

    lsu_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_load(req_load),
        .req_addr(req_addr), .req_reg(req_reg), .req_ready(req_ready), .done(done), .err(err),
        .m_addr(m_addr), .m_enable(m_enable), .m_rwn(m_rwn), .m_idata(m_idata),
        .m_ready(m_ready), .m_odata(m_odata), .m_data_valid(m_data_valid),
        .rf_wsel(rf_wsel), .rf_wdata(rf_wdata), .rf_we(rf_we), .rf_rsel(rf_rsel), .rf_rdata(rf_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [79:0] got, input logic [79:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic bound_fail(input string what);
        checks++;
        errors++;
        $display("FAIL %s: no response within cycle bound", what);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    function automatic logic [15:0] init_val(input int i);
        return i == 1 ? 16'd42 : i == 4 ? 16'h1234 : 16'(i * 257);
    endfunction

    // register file seen by the DUT
    logic [15:0] rf [16];
    assign rf_rdata = rf[rf_rsel];
    initial begin
        for (int i = 0; i < 16; i++) rf[i] <= init_val(i);
        forever begin
            @(posedge clk);
            if (rf_we) rf[rf_wsel] <= rf_wdata;
        end
    end

    // memunit responder
    logic [15:0] mem [0:65535];
    bit          stuck = 0, dv_rdy = 0, dv_st = 0;
    int          ndv = 1, lat = 2, init_cnt = 0, busy = 0;
    bit          ph = 0, rd = 0;
    logic [15:0] ra = 16'd0, rw = 16'd0;
    initial forever begin
        @(posedge clk);
        #1;
        m_data_valid = 1'b0;
        if (!nrst) begin
            ph = 0;
            m_ready = 1'b1;
        end else if (init_cnt > 0) begin
            init_cnt--;
            m_ready = 1'b0;
        end else if (!ph) begin
            m_ready = 1'b1;
            if (m_enable && !stuck) begin
                ph = 1; busy = lat; ra = m_addr; rd = m_rwn; rw = m_idata;
                m_ready = 1'b0;
            end
        end else begin
            busy--;
            if (busy == 0) begin
                ph = 0;
                m_ready = 1'b1;
                if (!rd) mem[ra] = rw;
                if (rd && dv_rdy) begin
                    m_data_valid = 1'b1;
                    m_odata = mem[ra];
                end
            end else if (busy <= ndv && (rd || dv_st)) begin
                m_data_valid = 1'b1;
                m_odata = (busy == ndv) ? mem[ra] : 16'hBAD0;
            end
        end
    end

    // transaction-level model
    typedef struct {
        logic        load;
        logic [15:0] addr;
        logic [3:0]  rg;
        logic [15:0] exp_data;
        logic [15:0] exp_idata;
        logic        exp_err;
        int          exp_we;
        int          exp_en;
    } txn_t;

    txn_t        cur, t;
    logic [15:0] exp_rf [16];
    logic [15:0] exp_mem [0:65535];
    logic [15:0] last_idata = 16'd0;
    int          nacc = 0, ndone = 0, d0 = 0, cyc = 0;
    int          acc_cyc = 0, we_cyc = 0, en_cnt = 0, we_cnt = 0;
    int          last_lat = 0, last_we_gap = 0, last_en = 0, last_we = 0;
    logic        last_err = 1'b0;
    bit          act = 0, pend = 0;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (!nrst) begin
            act = 0;
            pend = 0;
        end else begin
            if (pend) begin
                pend = 0;
                if (t.load && t.exp_we == 1) chk("rf_val", 80'(rf[t.rg]), 80'(t.exp_data));
                if (!t.load) chk("mem_val", 80'(mem[t.addr]), 80'(t.exp_idata));
            end
            if (!act) begin
                chk("idle_outs", 80'({req_ready, m_enable, done, err, rf_we}), 80'(5'b10000));
                if (req_valid && req_ready) begin
                    t = cur; act = 1; nacc++; acc_cyc = cyc; en_cnt = 0; we_cnt = 0;
                end
            end else begin
                chk("busy_outs", 80'({req_ready, err & ~done, m_addr, m_rwn, rf_rsel}),
                    80'({1'b0, 1'b0, t.addr, t.load, t.rg}));
                if (m_enable) en_cnt++;
                if (rf_we) begin
                    chk("rf_write", 80'({rf_wsel, rf_wdata}), 80'({t.rg, t.exp_data}));
                    we_cnt++;
                    we_cyc = cyc;
                end
                if (done) begin
                    chk("err", 80'(err), 80'(t.exp_err));
                    chk("we_count", 80'(we_cnt), 80'(t.exp_we));
                    chk("en_cycles", 80'(en_cnt), 80'(t.exp_en));
                    chk("m_idata", 80'(m_idata), 80'(t.exp_idata));
                    if (t.load && t.exp_we == 1) exp_rf[t.rg] = t.exp_data;
                    last_lat = cyc - acc_cyc; last_we_gap = cyc - we_cyc;
                    last_en = en_cnt; last_we = we_cnt; last_err = err;
                    act = 0; pend = 1; ndone++;
                end
            end
        end
    end

    task automatic start(input logic ld, input logic [15:0] a, input logic [3:0] r);
        int n0;
        @(posedge clk);
        #1;
        cur.load = ld; cur.addr = a; cur.rg = r;
        cur.exp_en = stuck ? int'(TMO) : 1;
        cur.exp_idata = ld ? last_idata : exp_rf[r];
        cur.exp_data = exp_mem[a];
        cur.exp_we = (ld && !stuck && (dv_rdy || ndv > 0)) ? 1 : 0;
        cur.exp_err = stuck || (ld && cur.exp_we == 0);
        if (!ld) begin
            exp_mem[a] = exp_rf[r];
            last_idata = exp_rf[r];
        end
        req_load = ld; req_addr = a; req_reg = r; req_valid = 1'b1;
        n0 = nacc;
        d0 = ndone;
        for (int i = 0; nacc == n0; i++) begin
            if (i == 300) bound_fail("accept");
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic run(input logic ld, input logic [15:0] a, input logic [3:0] r);
        start(ld, a, r);
        for (int i = 0; ndone == d0; i++) begin
            if (i == 300) bound_fail("done");
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int init);
        @(negedge clk);
        #2;
        nrst = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("rst_outs", 80'({req_ready, done, err, m_enable, m_rwn, rf_we, m_addr, m_idata, rf_wsel, rf_wdata, rf_rsel}), 80'(0));
        last_idata = 16'd0;
        repeat (2) @(negedge clk);
        chk("rst_hold", 80'({req_ready, done, err, m_enable, rf_we}), 80'(0));
        init_cnt = init;
        #2;
        nrst = 1'b1;
        chk("rdy_low", 80'(req_ready), 80'(0));
        @(posedge clk);
        #1;
        chk("rdy_rise", 80'(req_ready), 80'(1));
    endtask

    task automatic wait_enable(input logic lvl);
        for (int i = 0; m_enable !== lvl; i++) begin
            if (i == 100) bound_fail("m_enable");
            @(negedge clk);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) exp_rf[i] = init_val(i);
        do_reset(5);
        lat = 2; ndv = 1;
        run(1'b0, 16'hDEAD, 4'd1);
        chk("t1_idata", 80'(m_idata), 80'(42));
        chk("t1_rwn", 80'(m_rwn), 80'(0));
        chk("t1_err", 80'(last_err), 80'(0));
        run(1'b1, 16'hDEAD, 4'd2);
        run(1'b0, 16'h0010, 4'd4);
        run(1'b1, 16'h0010, 4'd3);
        dv_rdy = 1; ndv = 0; lat = 1;
        run(1'b1, 16'h0010, 4'd5);
        chk("t4_latency", 80'(last_lat), 80'(4));
        chk("t4_we_done_gap", 80'(last_we_gap), 80'(0));
        dv_rdy = 0; ndv = 2; dv_st = 1; lat = 3;
        run(1'b0, 16'h0020, 4'd6);
        run(1'b1, 16'h0020, 4'd7);
        ndv = 0; dv_st = 0; lat = 2;
        run(1'b1, 16'h0010, 4'd8);
        chk("t6_err", 80'(last_err), 80'(1));
        stuck = 1;
        run(1'b1, 16'h0010, 4'd9);
        chk("t7_en", 80'(last_en), 80'(16));
        chk("t7_err", 80'(last_err), 80'(1));
        chk("t7_we", 80'(last_we), 80'(0));
        start(1'b1, 16'h0010, 4'd9);
        wait_enable(1'b1);
        do_reset(0);
        stuck = 0; lat = 8; ndv = 1;
        start(1'b1, 16'hDEAD, 4'd10);
        wait_enable(1'b1);
        wait_enable(1'b0);
        @(negedge clk);
        do_reset(0);
        lat = 2;
        run(1'b1, 16'hDEAD, 4'd10);
        chk("t9_idata", 80'(m_idata), 80'(0));
        repeat (2) @(negedge clk);
        chk("r2", 80'(rf[2]), 80'(42));
        chk("r3", 80'(rf[3]), 80'(16'h1234));
        chk("r5", 80'(rf[5]), 80'(16'h1234));
        chk("r7", 80'(rf[7]), 80'(16'h0606));
        chk("r8", 80'(rf[8]), 80'(16'h0808));
        chk("r9", 80'(rf[9]), 80'(16'h0909));
        chk("r10", 80'(rf[10]), 80'(42));
        chk("mem_dead", 80'(mem[16'hDEAD]), 80'(42));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16'd4096: max cycles per memunit handshake phase before abort.
REQ-002 SHALL have clk, input, 1: the single clock; all state changes on posedge clk.
REQ-003 SHALL have nrst, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have req_valid, input, 1: CPU load/store request present.
REQ-005 SHALL have req_load, input, 1: 1 = load (memory to register), 0 = store.
REQ-006 SHALL have req_addr, input, 16: memory word address.
REQ-007 SHALL have req_reg, input, 4: destination register (load) or source register (store).
REQ-008 SHALL have req_ready, output, 1: controller idle and accepting a request.
REQ-009 SHALL have done, output, 1: one-cycle completion pulse.
REQ-010 SHALL have err, output, 1: one-cycle pulse, coincident with done, on timeout or missing read data.
REQ-011 SHALL have m_addr (output, 16), m_enable (output, 1), m_rwn (output, 1; 1 = read) and m_idata (output, 16), driving memunit.
REQ-012 SHALL have m_ready (input, 1), m_odata (input, 16) and m_data_valid (input, 1), from memunit.
REQ-013 SHALL have rf_wsel (output, 4), rf_wdata (output, 16) and rf_we (output, 1): regfile write port.
REQ-014 SHALL have rf_rsel (output, 4) and rf_rdata (input, 16): regfile read port; read is combinational.

Function
REQ-015 SHALL implement states IDLE, ARM, ISSUE, WAIT, DONE.
REQ-016 IDLE: req_ready=1. On req_valid=1 SHALL latch req_addr, req_load and req_reg, drive req_ready=0, and go to ARM.
REQ-017 SHALL drive rf_rsel from the latched register continuously; m_addr SHALL equal the latched address; m_rwn SHALL equal the latched req_load.
REQ-018 ARM: wait for m_ready=1. In the cycle m_ready=1 is seen, SHALL load m_idata<=rf_rdata (store only; load leaves it unchanged), set m_enable<=1, and go to ISSUE.
REQ-019 ISSUE: hold m_enable=1 until m_ready=0 is sampled, then set m_enable<=0 and go to WAIT; m_enable SHALL never be high outside ISSUE.
REQ-020 WAIT: on m_data_valid=1 with a load, SHALL assert rf_we=1 for exactly one cycle with rf_wsel=latched reg and rf_wdata=m_odata, and set flag got_data.
REQ-021 WAIT: on m_ready=1, SHALL go to DONE.
REQ-022 m_data_valid during a store, or a second m_data_valid in one load, SHALL be ignored (no rf_we).
REQ-023 If m_data_valid and the m_ready rise coincide, SHALL perform the regfile write and the transition to DONE in the same cycle.
REQ-024 DONE: done=1 for one cycle; err=1 if load with got_data=0; then SHALL go to IDLE with req_ready=1 the following cycle.
REQ-025 A 16-bit phase counter SHALL clear on entry to ARM, ISSUE and WAIT and increment each cycle spent there.
REQ-026 If the phase counter reaches TIMEOUT_CYCLES, SHALL force m_enable=0, skip any regfile write, and go to DONE with err=1.
REQ-027 Minimum latency (memunit ready, immediate handshake) SHALL be accept -> ARM -> ISSUE -> WAIT -> DONE.
REQ-028 No request SHALL be accepted while req_ready=0; req_valid is sampled only in IDLE.

Reset
REQ-029 While nrst=0: state IDLE; req_ready, done, err, m_enable, m_rwn and rf_we = 0; m_addr, m_idata, rf_wsel, rf_wdata, rf_rsel and counter = 0; got_data cleared.
REQ-030 req_ready SHALL rise on the first posedge clk after nrst deasserts.
REQ-031 Reset asserted mid-transaction SHALL abort immediately (m_enable=0 asynchronously), with no done, err or rf_we pulse.

Verification
REQ-032 Store: r1=42, req_load=0, req_addr=16'hDEAD, req_reg=1, held while memunit initializes -> m_enable held until m_ready=0, m_idata=42, m_rwn=0, done pulse, err=0.
REQ-033 Load: req_load=1, req_addr=16'hDEAD, req_reg=2 after REQ-032 -> single rf_we pulse with rf_wsel=2, rf_wdata=42; r2 reads 42; done=1, err=0.
REQ-034 Back-to-back: store 16'h1234 to 16'h0010, then load from 16'h0010 to r3 issued the cycle req_ready rises -> r3=16'h1234; no overlapping m_enable.
REQ-035 Coincident m_data_valid and m_ready rise in a model responder -> rf_we and done separated by exactly the REQ-023/REQ-024 ordering; data correct.
REQ-036 Timeout: responder never drops m_ready, TIMEOUT_CYCLES=16 -> m_enable low after 16 ISSUE cycles; done=1, err=1; no rf_we.
REQ-037 nrst pulsed low during WAIT of a load -> all outputs at reset values; no rf_we; next request completes normally.
